// File: rtl/hit_detect.sv
// Per-frame sprite/projectile collision judge: latches overlap over the visible
// area, issues one-cycle damage/despawn pulses at vblank start, and tracks cooldowns.
module hit_detect #(
  parameter int unsigned INVULN_FRAMES = 30,
  parameter int unsigned CD_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  input  logic hblnk,
  input  logic cat_px,
  input  logic dog_px,
  input  logic cat_proj_px,
  input  logic dog_proj_px,
  input  logic game_active,
  output logic hit_cat,
  output logic hit_dog,
  output logic cat_proj_clr,
  output logic dog_proj_clr,
  output logic cat_invuln,
  output logic dog_invuln
);

  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(INVULN_FRAMES);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

  logic            vblnk_q,   vblnk_d;
  logic            ov_cat_q,  ov_cat_d;
  logic            ov_dog_q,  ov_dog_d;
  logic [CD_W-1:0] cd_cat_q,  cd_cat_d;
  logic [CD_W-1:0] cd_dog_q,  cd_dog_d;
  logic            hit_cat_q, hit_cat_d;
  logic            hit_dog_q, hit_dog_d;
  logic            cat_inv_q, cat_inv_d;
  logic            dog_inv_q, dog_inv_d;

  logic frame_edge;
  logic visible;

  // Overlap accumulation, once-per-frame hit judgement and cooldown update
  always_comb begin
    frame_edge = vblnk & ~vblnk_q;
    visible    = ~vblnk & ~hblnk;
    vblnk_d    = vblnk;
    ov_cat_d   = ov_cat_q;
    ov_dog_d   = ov_dog_q;
    cd_cat_d   = cd_cat_q;
    cd_dog_d   = cd_dog_q;
    hit_cat_d  = 1'b0;
    hit_dog_d  = 1'b0;

    if (frame_edge) begin
      ov_cat_d = 1'b0;
      ov_dog_d = 1'b0;

      if (ov_cat_q && (cd_cat_q == '0) && game_active) begin
        hit_cat_d = 1'b1;
        cd_cat_d  = CD_LOAD;
      end else if (cd_cat_q != '0) begin
        cd_cat_d  = cd_cat_q - CD_ONE;
      end

      if (ov_dog_q && (cd_dog_q == '0) && game_active) begin
        hit_dog_d = 1'b1;
        cd_dog_d  = CD_LOAD;
      end else if (cd_dog_q != '0) begin
        cd_dog_d  = cd_dog_q - CD_ONE;
      end
    end else if (visible) begin
      ov_cat_d = ov_cat_q | (cat_px & dog_proj_px);
      ov_dog_d = ov_dog_q | (dog_px & cat_proj_px);
    end

    // Invulnerability flag tracks the cooldown value being loaded this cycle
    cat_inv_d = (cd_cat_d != '0);
    dog_inv_d = (cd_dog_d != '0);
  end

  // vblnk_q resets high so a blanking level present at reset release is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_q   <= 1'b1;
      ov_cat_q  <= 1'b0;
      ov_dog_q  <= 1'b0;
      cd_cat_q  <= '0;
      cd_dog_q  <= '0;
      hit_cat_q <= 1'b0;
      hit_dog_q <= 1'b0;
      cat_inv_q <= 1'b0;
      dog_inv_q <= 1'b0;
    end else begin
      vblnk_q   <= vblnk_d;
      ov_cat_q  <= ov_cat_d;
      ov_dog_q  <= ov_dog_d;
      cd_cat_q  <= cd_cat_d;
      cd_dog_q  <= cd_dog_d;
      hit_cat_q <= hit_cat_d;
      hit_dog_q <= hit_dog_d;
      cat_inv_q <= cat_inv_d;
      dog_inv_q <= dog_inv_d;
    end
  end

  // A projectile that lands is despawned in the same cycle its victim is damaged
  assign hit_cat      = hit_cat_q;
  assign hit_dog      = hit_dog_q;
  assign dog_proj_clr = hit_cat_q;
  assign cat_proj_clr = hit_dog_q;
  assign cat_invuln   = cat_inv_q;
  assign dog_invuln   = dog_inv_q;

endmodule
